// File: rtl/fetch_stage.sv
// Y86-64 fetch stage: F register (predicted PC), fetch-PC select, instruction split,
// valP / next-PC prediction, status generation and a RUN/HOLD halt FSM.
module fetch_stage #(
    parameter int          n        = 64,
    parameter logic [n-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         F_stall,
    input  logic [3:0]   M_icode,
    input  logic         M_Cnd,
    input  logic [n-1:0] M_valA,
    input  logic [3:0]   W_icode,
    input  logic [n-1:0] W_valM,
    output logic [n-1:0] imem_addr,
    input  logic [79:0]  imem_data,
    input  logic         imem_error,
    output logic [3:0]   f_icode,
    output logic [3:0]   f_ifun,
    output logic [3:0]   f_rA,
    output logic [3:0]   f_rB,
    output logic [n-1:0] f_valC,
    output logic [n-1:0] f_valP,
    output logic [2:0]   f_stat,
    output logic [n-1:0] F_predPC
);
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic {RUN, HOLD} state_t;

    state_t       state_reg, state_next;
    logic [n-1:0] pred_pc_reg, pred_pc_next;

    logic         mispredict, ret_redirect, redirect, bubble;
    logic [n-1:0] pc;
    logic [7:0]   ib [10];
    logic [63:0]  valc_short, valc_long;
    logic [3:0]   icode, ifun;
    logic         need_regids, need_valc, instr_valid;
    logic [63:0]  valc_raw;
    logic [n-1:0] valp_raw, pred_pc;
    logic [2:0]   stat_raw;

    assign mispredict   = (M_icode == 4'h7) && !M_Cnd;
    assign ret_redirect = (W_icode == 4'h9);
    assign redirect     = mispredict || ret_redirect;
    assign pc           = mispredict ? M_valA : (ret_redirect ? W_valM : pred_pc_reg);
    assign imem_addr    = pc;
    assign F_predPC     = pred_pc_reg;

    // In HOLD the fetch is suppressed unless a redirect restarts the pipeline.
    assign bubble = (state_reg == HOLD) && !redirect;

    genvar gi;
    generate
        for (gi = 0; gi < 10; gi++) begin : g_bytes
            assign ib[gi] = imem_data[8*gi +: 8];
        end
        // valC starts at byte 1 without register ids, byte 2 with them.
        for (gi = 0; gi < 8; gi++) begin : g_valc
            assign valc_short[8*gi +: 8] = ib[gi+1];
            assign valc_long[8*gi +: 8]  = ib[gi+2];
        end
    endgenerate

    assign icode = ib[0][7:4];
    assign ifun  = ib[0][3:0];

    always_comb begin
        need_regids = 1'b0;
        need_valc   = 1'b0;
        instr_valid = 1'b1;
        case (icode)
            4'h0, 4'h1, 4'h9:       instr_valid = (ifun == 4'h0);
            4'h2:                   begin need_regids = 1'b1; instr_valid = (ifun <= 4'h6); end
            4'h3, 4'h4, 4'h5:       begin need_regids = 1'b1; need_valc = 1'b1; instr_valid = (ifun == 4'h0); end
            4'h6:                   begin need_regids = 1'b1; instr_valid = (ifun <= 4'h3); end
            4'h7:                   begin need_valc = 1'b1; instr_valid = (ifun <= 4'h6); end
            4'h8:                   begin need_valc = 1'b1; instr_valid = (ifun == 4'h0); end
            4'hA, 4'hB:             begin need_regids = 1'b1; instr_valid = (ifun == 4'h0); end
            default:                instr_valid = 1'b0;
        endcase
    end

    assign valc_raw = need_valc ? (need_regids ? valc_long : valc_short) : 64'd0;
    assign valp_raw = pc + n'({need_valc, 3'b000} + {3'b000, need_regids} + 4'd1);
    assign pred_pc  = (icode == 4'h7 || icode == 4'h8) ? n'(valc_raw) : valp_raw;

    always_comb begin
        if (imem_error)        stat_raw = STAT_ADR;
        else if (!instr_valid) stat_raw = STAT_INS;
        else if (icode == 4'h0) stat_raw = STAT_HLT;
        else                   stat_raw = STAT_AOK;
    end

    always_comb begin
        f_icode = icode;
        f_ifun  = ifun;
        f_rA    = need_regids ? ib[1][7:4] : 4'hF;
        f_rB    = need_regids ? ib[1][3:0] : 4'hF;
        f_valC  = n'(valc_raw);
        f_valP  = valp_raw;
        f_stat  = stat_raw;
        if (bubble || imem_error) begin
            f_icode = 4'h1;
            f_ifun  = 4'h0;
            f_rA    = 4'hF;
            f_rB    = 4'hF;
            f_valC  = '0;
        end
        if (bubble) begin
            f_valP = pred_pc_reg;
            f_stat = STAT_AOK;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pred_pc_next = pred_pc_reg;
        if (!bubble) begin
            state_next   = (stat_raw != STAT_AOK) ? HOLD : RUN;
            pred_pc_next = pred_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= RUN;
            pred_pc_reg <= RESET_PC;
        end else if (!F_stall) begin
            state_reg   <= state_next;
            pred_pc_reg <= pred_pc_next;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboarded bench for fetch_stage: stimulus pushes hand-computed expectations,
// a monitor pops and compares them once per cycle on the falling edge.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        F_stall = 1'b0;
    logic [3:0]  M_icode = 4'h0;
    logic        M_Cnd = 1'b0;
    logic [63:0] M_valA = '0;
    logic [3:0]  W_icode = 4'h0;
    logic [63:0] W_valM = '0;
    logic [63:0] imem_addr;
    logic [79:0] imem_data;
    logic        imem_error = 1'b0;
    logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
    logic [63:0] f_valC, f_valP, F_predPC;
    logic [2:0]  f_stat;

    fetch_stage #(.n(64), .RESET_PC(64'h0)) dut (
        .clk(clk), .rst_n(rst_n), .F_stall(F_stall),
        .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valA(M_valA),
        .W_icode(W_icode), .W_valM(W_valM),
        .imem_addr(imem_addr), .imem_data(imem_data), .imem_error(imem_error),
        .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
        .f_valC(f_valC), .f_valP(f_valP), .f_stat(f_stat), .F_predPC(F_predPC)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:1023];

    always_comb begin
        imem_data = '0;
        for (int k = 0; k < 10; k++)
            imem_data[8*k +: 8] = mem[(int'(imem_addr[9:0]) + k) % 1024];
    end

    typedef struct packed {
        logic [63:0] addr;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
        logic [2:0]  stat;
        logic [63:0] pred;
        logic        chk_valp;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    function automatic exp_t mk(logic [63:0] a, logic [3:0] i, logic [3:0] f, logic [3:0] ra,
                                logic [3:0] rb, logic [63:0] c, logic [63:0] p, logic [2:0] s,
                                logic [63:0] pr, logic cv = 1'b1);
        exp_t e;
        e.addr = a; e.icode = i; e.ifun = f; e.ra = ra; e.rb = rb;
        e.valc = c; e.valp = p; e.stat = s; e.pred = pr; e.chk_valp = cv;
        return e;
    endfunction

    // Nop bubble emitted in HOLD: fetch PC, valP and F_predPC all equal the frozen PC.
    function automatic exp_t bub(logic [63:0] a);
        return mk(a, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, a, 3'd1, a);
    endfunction

    task automatic put(input int a, input logic [79:0] v);
        for (int k = 0; k < 10; k++) mem[a + k] = v[8*k +: 8];
    endtask

    task automatic expect_now(input string nm, input exp_t e);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic step(input string nm, input exp_t e);
        expect_now(nm, e);
        @(posedge clk);
        #1;
    endtask

    task automatic set_redir(input logic [3:0] mi, input logic [63:0] ma,
                             input logic [3:0] wi, input logic [63:0] wm);
        M_icode = mi; M_Cnd = 1'b0; M_valA = ma; W_icode = wi; W_valM = wm;
    endtask

    // Monitor: compare whatever expectation is pending against the settled outputs.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t  e, act;
                string nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                act = mk(imem_addr, f_icode, f_ifun, f_rA, f_rB, f_valC,
                         e.chk_valp ? f_valP : e.valp, f_stat, F_predPC, e.chk_valp);
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL %s: got addr=%h icode=%h ifun=%h rA=%h rB=%h valC=%h valP=%h stat=%0d predPC=%h; expected addr=%h icode=%h ifun=%h rA=%h rB=%h valC=%h valP=%h stat=%0d predPC=%h",
                             nm, imem_addr, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP, f_stat, F_predPC,
                             e.addr, e.icode, e.ifun, e.ra, e.rb, e.valc, e.valp, e.stat, e.pred);
                end else begin
                    $display("ok   %s: addr=%h icode=%h stat=%0d predPC=%h", nm, imem_addr, f_icode, f_stat, F_predPC);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the end of stimulus");
        $fatal(1, "timeout");
    end

    localparam exp_t E_RESET  = '{64'h0, 4'h3, 4'h0, 4'hF, 4'h2, 64'hA, 64'hA, 3'd1, 64'h0, 1'b1};
    localparam exp_t E_NOP_0A = '{64'hA, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'hB, 3'd1, 64'hA, 1'b1};

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        put(16'h000, 80'h0AF230);                // irmovq $10,%rdx
        put(16'h00A, 80'h10);                    // nop
        put(16'h00B, 80'h2070);                  // jmp 0x20
        put(16'h020, 80'h010073);                // je 0x100
        put(16'h029, 80'h0120);                  // rrmovq %rax,%rcx ; 0x2B stays halt
        put(16'h040, 80'h2360);                  // addq %rdx,%rbx
        put(16'h050, 80'h10);                    // nop
        put(16'h051, 80'hC0);                    // invalid icode
        put(16'h060, 80'h1265);                  // OPq with ifun 5
        put(16'h080, 80'h1122334455667788F330);  // irmovq $0x1122334455667788,%rbx
        put(16'h08A, 80'h020080);                // call 0x200
        put(16'h100, 80'h2360);
        put(16'h200, 80'h90);                    // ret

        // Reset state, then release between edges.
        @(posedge clk);
        #1;
        expect_now("reset_irmovq", E_RESET);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        step("seq_nop_0A", E_NOP_0A);
        step("jmp_0B", mk(64'hB, 4'h7, 4'h0, 4'hF, 4'hF, 64'h20, 64'h14, 3'd1, 64'hB));
        step("je_20", mk(64'h20, 4'h7, 4'h3, 4'hF, 4'hF, 64'h100, 64'h29, 3'd1, 64'h20));

        set_redir(4'h7, 64'h29, 4'h0, 64'h0);
        step("mispredict_29", mk(64'h29, 4'h2, 4'h0, 4'h0, 4'h1, 64'h0, 64'h2B, 3'd1, 64'h100));
        set_redir(4'h0, 64'h0, 4'h9, 64'h40);
        step("ret_redirect_40", mk(64'h40, 4'h6, 4'h0, 4'h2, 4'h3, 64'h0, 64'h42, 3'd1, 64'h2B));
        set_redir(4'h7, 64'h29, 4'h9, 64'h40);
        step("both_redirect_M_wins", mk(64'h29, 4'h2, 4'h0, 4'h0, 4'h1, 64'h0, 64'h2B, 3'd1, 64'h42));
        set_redir(4'h0, 64'h0, 4'h0, 64'h0);

        step("halt_2B", mk(64'h2B, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h2C, 3'd2, 64'h2B));
        step("hold_bubble_1", bub(64'h2C));
        step("hold_bubble_2", bub(64'h2C));
        set_redir(4'h7, 64'h50, 4'h0, 64'h0);
        step("hold_redirect_50", mk(64'h50, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h51, 3'd1, 64'h2C));
        set_redir(4'h0, 64'h0, 4'h0, 64'h0);

        step("invalid_C0", mk(64'h51, 4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'h52, 3'd4, 64'h51));
        step("hold_bubble_52", bub(64'h52));
        set_redir(4'h0, 64'h0, 4'h9, 64'h60);
        step("invalid_ifun_65", mk(64'h60, 4'h6, 4'h5, 4'h1, 4'h2, 64'h0, 64'h62, 3'd4, 64'h52));
        set_redir(4'h0, 64'h0, 4'h0, 64'h0);
        step("hold_bubble_62", bub(64'h62));

        // Stall for three cycles; the first carries a redirect that must not update F.
        F_stall = 1'b1;
        set_redir(4'h7, 64'h80, 4'h0, 64'h0);
        step("stall_redirect_80", mk(64'h80, 4'h3, 4'h0, 4'hF, 4'h3, 64'h1122334455667788, 64'h8A, 3'd1, 64'h62));
        set_redir(4'h0, 64'h0, 4'h0, 64'h0);
        step("stall_bubble_2", bub(64'h62));
        step("stall_bubble_3", bub(64'h62));
        F_stall = 1'b0;
        step("unstall_still_hold", bub(64'h62));
        set_redir(4'h7, 64'h80, 4'h0, 64'h0);
        step("redirect_80", mk(64'h80, 4'h3, 4'h0, 4'hF, 4'h3, 64'h1122334455667788, 64'h8A, 3'd1, 64'h62));
        set_redir(4'h0, 64'h0, 4'h0, 64'h0);

        step("call_8A", mk(64'h8A, 4'h8, 4'h0, 4'hF, 4'hF, 64'h200, 64'h93, 3'd1, 64'h8A));
        step("ret_200", mk(64'h200, 4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'h201, 3'd1, 64'h200));
        imem_error = 1'b1;
        step("imem_error_201", mk(64'h201, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 3'd3, 64'h201, 1'b0));
        imem_error = 1'b0;

        // Asynchronous reset between edges while in HOLD.
        #2;
        rst_n = 1'b0;
        #1;
        expect_now("async_reset_midcycle", E_RESET);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step("after_reset_nop_0A", E_NOP_0A);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Fetch stage of the Y86-64 pipelined core; sits directly upstream of the decode pipeline register and drives its f_* inputs. Holds the F pipeline register (predicted PC), selects the fetch PC (prediction, mispredicted-branch recovery, or return address), and splits the 10-byte instruction window into icode/ifun/rA/rB/valC. It computes valP, predicts the next PC and produces a fetch status. A two-state halt FSM stops speculative fetching after a halt, invalid instruction or address error until a redirect arrives.

## Interface
- n, 64, datapath / address width
- RESET_PC, 64'h0, value loaded into F_predPC on reset

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- F_stall  in  1  hold F register and FSM this cycle
- M_icode  in  4  icode in memory stage
- M_Cnd  in  1  branch condition in memory stage
- M_valA  in  n  fall-through PC of the jump in memory stage
- W_icode  in  4  icode in write-back stage
- W_valM  in  n  return address loaded by ret in write-back
- imem_addr  out  n  fetch PC (combinational read address)
- imem_data  in  80  bytes PC..PC+9, byte k at [8k+7:8k]
- imem_error  in  1  fetch address invalid
- f_icode, f_ifun, f_rA, f_rB  out  4 each  decoded fields
- f_valC  out  n  constant word
- f_valP  out  n  PC of next sequential instruction
- f_stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS
- F_predPC  out  n  F register contents

## Operation
- PC select, priority order: M_icode==7 && !M_Cnd -> M_valA; else W_icode==9 -> W_valM; else F_predPC. "redirect" = either of the first two true. imem_addr = selected PC.
- Byte0: icode=[7:4], ifun=[3:0].
- need_regids = icode in {2,3,4,5,6,A,B}. If set, rA=byte1[7:4], rB=byte1[3:0]; else rA=rB=4'hF.
- need_valC = icode in {3,4,5,7,8}. valC = 8 little-endian bytes starting at byte (1+need_regids); else 0.
- valP = PC + 1 + need_regids + 8*need_valC, mod 2^64.
- Valid: icode<=B; ifun<=6 for icode 2,7; ifun<=3 for icode 6; ifun==0 otherwise.
- f_stat: imem_error -> ADR, with f_icode=1, f_ifun=0, rA=rB=F, valC=0. Else invalid -> INS, with fields passed through. Else icode 0 -> HLT. Else AOK.
- Next-PC prediction: icode 7 or 8 -> valC; else valP.
- FSM states RUN, HOLD.
  - RUN: if !F_stall and f_stat != AOK -> HOLD.
  - HOLD without redirect: outputs are a nop bubble (f_icode=1, f_ifun=0, rA=rB=F, valC=0, valP=F_predPC, stat AOK); F_predPC is unchanged.
  - HOLD with redirect: the cycle behaves exactly as RUN, fetching at the redirect PC, and the next state follows RUN rules.
- F_stall=1: F_predPC and state hold; outputs are still computed combinationally.

## Timing
- Async reset: F_predPC=RESET_PC, state=RUN immediately. Outputs then reflect fetch at RESET_PC.
- All f_* outputs and imem_addr are combinational from F_predPC, state, redirect inputs and imem_data. Zero-cycle latency to the decode register, which captures them on the next edge.
- On each rising edge with !F_stall: F_predPC <= predicted next PC (RUN or redirect cycle) or unchanged (HOLD without redirect), and the state updates.
- Redirect and F_stall in the same cycle: the redirect PC is used for the fetch, but F is not updated.
- Redirect during RUN resulting in a non-AOK fetch -> HOLD, same as any other fetch.
- Reset mid-HOLD -> RUN at RESET_PC.

## Test plan
- Reset, RESET_PC=0, imem bytes 30 F2 0A 00.. (irmovq $10,%rdx) -> f_icode 3, rA F, rB 2, valC 10, valP 10, stat 1; next edge imem_addr=10.
- At 0x20, bytes 73 00 01 00.. (je 0x100) -> valC 0x100, valP 0x29, F_predPC 0x100 next cycle. Then M_icode=7, M_Cnd=0, M_valA=0x29 -> imem_addr 0x29 that cycle.
- W_icode=9, W_valM=0x40 while M is not mispredicting -> imem_addr 0x40. Asserting both redirects together -> M_valA wins.
- Fetch byte 00 -> stat 2; following cycles emit nop bubble, F_predPC frozen. A mispredict redirect to 0x50 -> fetch at 0x50, state back to RUN.
- Byte C0 -> stat 4, HOLD. imem_error=1 -> stat 3, f_icode 1. Byte 65 (ifun 5 on OPq) -> stat 4.
- F_stall=1 for 3 cycles -> F_predPC unchanged. rst_n low mid-sequence (between edges) -> F_predPC=RESET_PC immediately.
